reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 255: number of CLK cycles sys_reset stays high after each reset trigger; legal range 1..65535.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1023: number of CLK cycles the synchronized button level must stay stable before it is accepted; legal range 1..65535.
REQ-003 CLK  in  1  system clock (PLL core output).
REQ-004 reset_in  in  1  reset, asynchronous, active-high.
REQ-005 pll_locked  in  1  PLL lock indicator; asynchronous to CLK.
REQ-006 greset_in  in  1  user reset button, active-high; asynchronous and bouncing.
REQ-007 sys_reset  out  1  active-high reset to the SoC; asserts asynchronously, deasserts synchronously to CLK.
REQ-008 reset_cause  out  2  cause of the last reset: 0 power-on, 1 lock loss, 2 button, 3 reserved.
REQ-009 reset_count  out  8  count of resets since reset_in; saturates at 255.

Function
REQ-010 pll_locked and greset_in SHALL each pass through a 2-flop synchronizer before any use; lock_s and btn_s denote the synchronized values.
REQ-011 FSM states: WAIT_LOCK, HOLD, RUN.
REQ-012 WAIT_LOCK: sys_reset=1; on lock_s=1, go to HOLD with hold counter cleared to 0.
REQ-013 HOLD: sys_reset=1; the hold counter increments each cycle; when counter==HOLD_CYCLES-1, go to RUN.
REQ-014 sys_reset SHALL be a register output driving 0 from the first cycle in RUN, so it is high for exactly HOLD_CYCLES cycles in HOLD.
REQ-015 RUN: sys_reset=0; lock_s=0 → WAIT_LOCK, reset_cause=1, reset_count+1.
REQ-016 RUN: an accepted button falling edge (debounced level 1→0, i.e. button release) → HOLD with counter cleared, reset_cause=2, reset_count+1.
REQ-017 Lock loss and accepted button release in the same RUN cycle: lock loss wins (cause=1, single increment).
REQ-018 HOLD: lock_s=0 → WAIT_LOCK (cause=1, count+1); accepted button release → restart counter at 0 (cause=2, count+1).
REQ-019 WAIT_LOCK: button events are ignored; cause and count are unchanged.
REQ-020 reset_count SHALL saturate at 255 and never wrap.
REQ-021 Latency: pll_locked rise → HOLD entry within 3 CLK cycles (2 synchronizer cycles plus 1 state register).

Reset
REQ-022 reset_in=1 SHALL immediately force sys_reset=1, state=WAIT_LOCK, hold counter=0, debounce counter=0, debounced level=0, reset_cause=0, reset_count=0, and synchronizer flops=0.
REQ-023 reset_in asserted in any state, mid-HOLD or mid-debounce, SHALL abandon all progress; after release, the sequencer restarts from WAIT_LOCK.

Configuration
REQ-024 Macro RESET_SEQ_DEBOUNCE_EN defined: the debounced level follows btn_s only after btn_s has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the current level clears the debounce counter.
REQ-025 Macro RESET_SEQ_DEBOUNCE_EN undefined: the debounced level equals btn_s delayed 1 cycle; DEBOUNCE_CYCLES is ignored and no debounce counter is synthesized.

Structure
REQ-026 Package reset_seq_pkg SHALL hold the FSM state enum and the cause constants CAUSE_POR=0, CAUSE_LOCK=1, CAUSE_BUTTON=2.
REQ-027 Sub-module sync2 (2-flop synchronizer, async reset to 0) SHALL be instantiated once for pll_locked and once for greset_in.

Verification (HOLD_CYCLES=4, DEBOUNCE_CYCLES=3)
REQ-028 Power-on: release reset_in with pll_locked=1 → sys_reset falls exactly 3+4 cycles later; cause=0, count=0.
REQ-029 Lock loss: drop pll_locked in RUN → sys_reset=1 within 3 cycles; cause=1, count=1; restore lock → 4-cycle hold, then release.
REQ-030 Button release: greset_in 1 for 10 cycles then 0 → one reset of 4 cycles; cause=2, count=1.
REQ-031 Bounce (debounce enabled): greset_in toggling every 2 cycles for 20 cycles, then stable 0 → no reset during bounce; at most one reset afterwards.
REQ-032 Simultaneous events: lock loss and accepted release in the same RUN cycle → cause=1, count increments by 1.
REQ-033 Saturation and mid-HOLD reset: 300 button resets → count=255; reset_in pulse mid-HOLD → all outputs back to reset values.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset-cause codes
// and a saturating counter helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR    = 2'd0;
  localparam logic [1:0] CAUSE_LOCK   = 2'd1;
  localparam logic [1:0] CAUSE_BUTTON = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; output lags the input by 2 CLK
// edges and both flops clear to 0 on reset_in.
module sync2 (
  input  logic CLK,
  input  logic reset_in,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset sequencer: waits for PLL lock, holds sys_reset for HOLD_CYCLES, and re-enters reset
// on lock loss or button release. Define RESET_SEQ_DEBOUNCE_EN to debounce the button.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = 255,
  parameter int DEBOUNCE_CYCLES = 1023
) (
  input  logic       CLK,
  input  logic       reset_in,
  input  logic       pll_locked,
  input  logic       greset_in,
  output logic       sys_reset,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_params
    $error("reset_sequencer: HOLD_CYCLES/DEBOUNCE_CYCLES outside 1..65535");
  end

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  logic       lock_s;
  logic       btn_s;
  logic       btn_db;
  logic       btn_db_nxt;
  logic       btn_release;

  seq_state_t state;
  seq_state_t state_nxt;
  logic [15:0] hold_cnt;
  logic [15:0] hold_nxt;
  logic [1:0]  cause_nxt;
  logic [7:0]  count_nxt;
  logic        sys_reset_nxt;

  sync2 u_sync_lock (
    .CLK      (CLK),
    .reset_in (reset_in),
    .d        (pll_locked),
    .q        (lock_s)
  );

  sync2 u_sync_btn (
    .CLK      (CLK),
    .reset_in (reset_in),
    .d        (greset_in),
    .q        (btn_s)
  );

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] db_cnt;
  logic [15:0] db_cnt_nxt;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    btn_db_nxt = btn_db;
    db_cnt_nxt = '0;
    if (btn_s != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db_nxt = btn_s;
      end else begin
        db_cnt_nxt = db_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt_nxt;
    end
  end
`else
  assign btn_db_nxt = btn_s;
`endif

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      btn_db <= 1'b0;
    end else begin
      btn_db <= btn_db_nxt;
    end
  end

  // Release is acted on at the same edge the debounced level drops.
  assign btn_release = btn_db & ~btn_db_nxt;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    cause_nxt = reset_cause;
    count_nxt = reset_count;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          hold_nxt  = '0;
          cause_nxt = CAUSE_LOCK;
          count_nxt = sat_inc8(reset_count);
        end else if (btn_release) begin
          hold_nxt  = '0;
          cause_nxt = CAUSE_BUTTON;
          count_nxt = sat_inc8(reset_count);
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          hold_nxt  = '0;
          cause_nxt = CAUSE_LOCK;
          count_nxt = sat_inc8(reset_count);
        end else if (btn_release) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
          cause_nxt = CAUSE_BUTTON;
          count_nxt = sat_inc8(reset_count);
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        hold_nxt  = '0;
      end
    endcase
    sys_reset_nxt = (state_nxt != RUN);
  end

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      reset_cause <= CAUSE_POR;
      reset_count <= '0;
      sys_reset   <= 1'b1;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      reset_cause <= cause_nxt;
      reset_count <= count_nxt;
      sys_reset   <= sys_reset_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations plus a per-cycle
// compare against a history-window behavioural model.
module tb_reset_sequencer;

  localparam int HOLD = 4;
  localparam int DBC  = 3;
`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int DB_N = DBC;
`else
  localparam int DB_N = 1;
`endif

  logic       CLK = 1'b0;
  logic       reset_in;
  logic       pll_locked;
  logic       greset_in;
  logic       sys_reset;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  int n_chk = 0;
  int n_bad = 0;

  reset_sequencer #(
    .HOLD_CYCLES     (HOLD),
    .DEBOUNCE_CYCLES (DBC)
  ) dut (
    .CLK         (CLK),
    .reset_in    (reset_in),
    .pll_locked  (pll_locked),
    .greset_in   (greset_in),
    .sys_reset   (sys_reset),
    .reset_cause (reset_cause),
    .reset_count (reset_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: raw input history per edge; synchronized value used at edge k is the input
  // sampled at edge k-2; the debounced level flips when the last DB_N used samples all differ.
  bit ph[$];
  bit bh[$];
  bit m_wait;
  int m_hold_left;
  int m_cause;
  int m_count;
  bit m_lvl;
  bit lock_u;
  bit all_diff;
  bit fall;

  task automatic model_reset();
    ph.delete();
    bh.delete();
    for (int i = 0; i < DB_N + 3; i++) begin
      ph.push_back(1'b0);
      bh.push_back(1'b0);
    end
    m_wait      = 1'b1;
    m_hold_left = 0;
    m_cause     = 0;
    m_count     = 0;
    m_lvl       = 1'b0;
  endtask

  task automatic bump();
    if (m_count < 255) m_count++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK);
      if (reset_in) begin
        model_reset();
      end else begin
        ph.push_back(pll_locked);
        bh.push_back(greset_in);
        void'(ph.pop_front());
        void'(bh.pop_front());
        lock_u   = ph[ph.size() - 3];
        all_diff = 1'b1;
        for (int i = 0; i < DB_N; i++) begin
          if (bh[bh.size() - 3 - i] == m_lvl) all_diff = 1'b0;
        end
        fall = m_lvl && all_diff;
        if (all_diff) m_lvl = !m_lvl;
        if (m_wait) begin
          if (lock_u) begin
            m_wait      = 1'b0;
            m_hold_left = HOLD;
          end
        end else if (!lock_u) begin
          m_wait      = 1'b1;
          m_hold_left = 0;
          m_cause     = 1;
          bump();
        end else if (fall) begin
          m_hold_left = HOLD;
          m_cause     = 2;
          bump();
        end else if (m_hold_left > 0) begin
          m_hold_left--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      chk("cyc_sys_reset", {31'd0, sys_reset}, {31'd0, (m_wait || m_hold_left > 0)});
      chk("cyc_cause", {30'd0, reset_cause}, m_cause);
      chk("cyc_count", {24'd0, reset_count}, m_count);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Counts clock edges until sys_reset reaches val; -1 if the budget expires.
  task automatic wait_sr(input logic val, input int budget, output int n);
    n = 0;
    while (sys_reset !== val && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (sys_reset !== val) n = -1;
  endtask

  task automatic do_reset(input string tag);
    reset_in = 1'b1;
    #1;
    chk({tag, "_rst_sys_reset"}, {31'd0, sys_reset}, 1);
    chk({tag, "_rst_cause"}, {30'd0, reset_cause}, 0);
    chk({tag, "_rst_count"}, {24'd0, reset_count}, 0);
    cyc(2);
    reset_in = 1'b0;
  endtask

  int n;
  int c0;

  initial begin
    reset_in   = 1'b1;
    pll_locked = 1'b1;
    greset_in  = 1'b0;
    cyc(3);

    // Power-on with lock already present.
    reset_in = 1'b0;
    wait_sr(1'b0, 50, n);
    chk("por_latency", n, 7);
    chk("por_cause", {30'd0, reset_cause}, 0);
    chk("por_count", {24'd0, reset_count}, 0);
    cyc(3);

    // Lock loss then relock.
    pll_locked = 1'b0;
    wait_sr(1'b1, 20, n);
    chk("lockloss_latency", n, 3);
    chk("lockloss_cause", {30'd0, reset_cause}, 1);
    chk("lockloss_count", {24'd0, reset_count}, 1);
    cyc(5);
    pll_locked = 1'b1;
    wait_sr(1'b0, 50, n);
    chk("relock_latency", n, 7);
    cyc(3);

    // Clean button press/release.
    do_reset("btn");
    wait_sr(1'b0, 50, n);
    chk("por2_latency", n, 7);
    greset_in = 1'b1;
    cyc(10);
    greset_in = 1'b0;
    wait_sr(1'b1, 20, n);
    chk("btn_latency", n, 2 + DB_N);
    wait_sr(1'b0, 20, n);
    chk("btn_hold_len", n, HOLD);
    chk("btn_cause", {30'd0, reset_cause}, 2);
    chk("btn_count", {24'd0, reset_count}, 1);
    cyc(3);

    // Bouncing button, 2-cycle toggles for 20 cycles.
    c0 = int'(reset_count);
    for (int i = 0; i < 10; i++) begin
      greset_in = (i % 2 == 0);
      cyc(2);
    end
    greset_in = 1'b0;
    cyc(10);
    chk("bounce_resets", int'(reset_count) - c0, (DB_N > 2) ? 0 : 5);

    // Lock loss and accepted release landing on the same edge.
    greset_in = 1'b1;
    cyc(DB_N + 4);
    chk("simul_pre_run", {31'd0, sys_reset}, 0);
    c0 = int'(reset_count);
    greset_in = 1'b0;
    cyc(DB_N - 1);
    pll_locked = 1'b0;
    cyc(5);
    chk("simul_sys_reset", {31'd0, sys_reset}, 1);
    chk("simul_cause", {30'd0, reset_cause}, 1);
    chk("simul_count", {24'd0, reset_count}, c0 + 1);
    pll_locked = 1'b1;
    wait_sr(1'b0, 50, n);
    chk("simul_relock", n, 7);
    cyc(2);

    // 300 button resets saturate the counter.
    for (int i = 0; i < 300; i++) begin
      greset_in = 1'b1;
      cyc(DB_N + 3);
      greset_in = 1'b0;
      cyc(DB_N + HOLD + 4);
    end
    chk("sat_count", {24'd0, reset_count}, 255);
    chk("sat_cause", {30'd0, reset_cause}, 2);

    // reset_in mid-HOLD abandons everything; sequencer restarts.
    greset_in = 1'b1;
    cyc(DB_N + 3);
    greset_in = 1'b0;
    cyc(DB_N + 3);
    chk("midhold_in_hold", {31'd0, sys_reset}, 1);
    do_reset("midhold");
    wait_sr(1'b0, 50, n);
    chk("midhold_restart", n, 7);
    chk("midhold_count", {24'd0, reset_count}, 0);
    cyc(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
